// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the unified memory-port arbiter:
//   - arb_state_t : arbiter FSM state encoding (IDLE=0, BUSY_I=1, BUSY_D=2,
//                   DONE=3)
//   - owner_t     : port-owner encoding, also driven on grant_owner
//                   (OWN_NONE=0, OWN_I=1 fetch, OWN_D=2 data)
//   - pick_owner  : round-robin selection between the two requesters
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Width of a fetched instruction word returned on if_rdata.
  localparam int IF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Chooses who gets the port next. A lone requester always wins; on a tie
  // the requester that did not own the port last time is granted, which
  // alternates service under sustained contention.
  function automatic owner_t pick_owner(
    input logic   if_req,
    input logic   d_req,
    input owner_t last_owner
  );
    owner_t winner;
    winner = OWN_NONE;
    if (if_req && d_req) begin
      winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (d_req) begin
      winner = OWN_D;
    end else if (if_req) begin
      winner = OWN_I;
    end
    return winner;
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// arb_timeout_ctr
//
// Counts BUSY cycles in which the memory has not answered and flags the cycle
// on which the TIMEOUT-th such cycle occurs, so the arbiter can abort on the
// same edge. TIMEOUT=0 removes the counter and never expires.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   clear    in   restart the count (arbiter entering BUSY)
//   enable   in   count this cycle (BUSY and memory not ready)
//   expired  out  combinational: this enabled cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [CNT_W-1:0] r_count;

      // NOTE: sequential state is written only with non-blocking assignments
      // so every register samples the pre-edge values of its inputs.
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          r_count <= '0;
        end else if (enable) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      // The count holds the number of earlier stalled cycles, so the current
      // enabled cycle is the TIMEOUT-th when the count equals TIMEOUT-1. The
      // counter never runs past that point because the arbiter leaves BUSY.
      assign expired = enable && (r_count == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, clear, enable};
      assign expired  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between the instruction-fetch and data requesters of
// the core. Each access is a single transaction IDLE -> BUSY_x -> DONE -> IDLE:
// the winning request's payload is latched on entry to BUSY, the memory is
// held in BUSY until mem_ready (or a timeout abort), and the requester's ack
// pulses for the one DONE cycle. Ties alternate round-robin, starting with data
// after reset. A timeout abort returns zero read data and sets a sticky
// bus_error.
//
// Ports:
//   clk, reset             clock (rising edge), synchronous active-high reset
//   if_req/if_addr         fetch request (level) and address
//   if_rdata/if_ack        fetched word (registered), one-cycle completion
//   d_req/d_we/d_addr/
//   d_wdata                data request (level), store flag, address, data
//   d_rdata/d_ack          load data (registered), one-cycle completion
//   mem_req/mem_we/
//   mem_addr/mem_wdata     memory-side access, all registered
//   mem_rdata/mem_ready    memory read data and completion
//   stall                  combinational: some request still awaits its ack
//   grant_owner            0 none, 1 fetch, 2 data (registered)
//   bus_error              sticky timeout flag
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // fetch requester
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic [IF_DATA_W-1:0] if_rdata,
  output logic                 if_ack,
  // data requester
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_ack,
  // memory port
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ready,
  // status
  output logic                 stall,
  output logic [1:0]           grant_owner,
  output logic                 bus_error
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  arb_state_t                 r_state;
  owner_t                     r_last_owner;
  owner_t                     r_grant_owner;
  logic                       r_mem_req;
  logic                       r_mem_we;
  logic [ADDR_W-1:0]          r_mem_addr;
  logic [DATA_W-1:0]          r_mem_wdata;
  logic [IF_DATA_W-1:0]       r_if_rdata;
  logic [DATA_W-1:0]          r_d_rdata;
  logic                       r_if_ack;
  logic                       r_d_ack;
  logic                       r_bus_error;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic   w_start;    // IDLE sees a request: enter BUSY this edge
  logic   w_busy;     // a memory access is in flight
  logic   w_wait;     // in flight and the memory has not answered
  logic   w_expired;  // this stalled cycle hits the timeout limit
  owner_t w_winner;

  assign w_winner = pick_owner(if_req, d_req, r_last_owner);
  assign w_start  = (r_state == ST_IDLE) && (if_req || d_req);
  assign w_busy   = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign w_wait   = w_busy && !mem_ready;

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_start),
    .enable  (w_wait),
    .expired (w_expired)
  );

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_owner  <= OWN_I;
      r_grant_owner <= OWN_NONE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_if_ack      <= 1'b0;
      r_d_ack       <= 1'b0;
      r_bus_error   <= 1'b0;
    end else begin
      // NOTE: the acks default low every edge and are raised only on the
      // BUSY->DONE edge, which makes each one a single-cycle pulse.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_grant_owner <= w_winner;
            r_last_owner  <= w_winner;
            r_mem_req     <= 1'b1;
            // Payload is captured here so requester changes during BUSY
            // cannot disturb the access on the memory port.
            if (w_winner == OWN_D) begin
              r_state     <= ST_BUSY_D;
              r_mem_addr  <= d_addr;
              r_mem_we    <= d_we;
              r_mem_wdata <= d_wdata;
            end else begin
              r_state     <= ST_BUSY_I;
              r_mem_addr  <= if_addr;
              r_mem_we    <= 1'b0;
              r_mem_wdata <= '0;
            end
          end
        end

        ST_BUSY_I, ST_BUSY_D: begin
          // mem_ready takes priority over a simultaneous timeout: the access
          // completed, so its data is kept and no error is flagged.
          if (mem_ready || w_expired) begin
            r_state   <= ST_DONE;
            r_mem_req <= 1'b0;
            if (r_state == ST_BUSY_I) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_ready ? mem_rdata[IF_DATA_W-1:0] : '0;
            end else begin
              r_d_ack <= 1'b1;
              // Stores return nothing; d_rdata keeps the last load result.
              if (!r_mem_we) begin
                r_d_rdata <= mem_ready ? mem_rdata : '0;
              end
            end
            if (!mem_ready) begin
              r_bus_error <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Requests are not looked at here; requesters drop req during the
          // ack cycle so IDLE does not see a stale request.
          r_state       <= ST_IDLE;
          r_grant_owner <= OWN_NONE;
        end

        default: begin
          r_state       <= ST_IDLE;
          r_grant_owner <= OWN_NONE;
          r_mem_req     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_ack      = r_if_ack;
  assign d_rdata     = r_d_rdata;
  assign d_ack       = r_d_ack;
  assign grant_owner = r_grant_owner;
  assign bus_error   = r_bus_error;

  // A request stalls the core until the cycle its ack is visible.
  assign stall = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Transaction-level reference model: the bench decides who is served from the
// round-robin rule, predicts the number of BUSY cycles from the memory delay
// and the timeout limit, and tracks the expected read-data registers and the
// sticky error flag. Directed scenarios run first, then randomized rounds.
// TIMEOUT is 5 so a 5-cycle store fits, with mem_ready arriving exactly on
// the cycle the count reaches the limit.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TIMEOUT_P = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic [63:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall;
  logic [1:0]  grant_owner;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (TIMEOUT_P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .grant_owner (grant_owner),
    .bus_error   (bus_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: 1 = fetch, 2 = data.
  int          m_last;
  logic [31:0] m_if_rdata;
  logic [63:0] m_d_rdata;
  logic        m_bus_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_last     = 1;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_bus_err  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_grant", grant_owner, 0);
    check("rst_bus_error", bus_error, 0);
  endtask

  // Serves one transaction for `owner`, starting at the negedge of an IDLE
  // cycle in which the request is visible; ends at the negedge of the IDLE
  // cycle after DONE. `delay` is the number of BUSY cycles with mem_ready low
  // before the memory answers with `rdat`.
  task automatic serve(input int owner, input int delay, input logic [63:0] rdat,
                       input bit perturb);
    logic [63:0] exp_addr, exp_wdata, got_rd;
    logic        exp_we, other_pending;
    bit          aborted;
    int          busy_len;
    exp_addr  = (owner == 1) ? if_addr : d_addr;
    exp_we    = (owner == 2) ? d_we : 1'b0;
    exp_wdata = (owner == 2) ? d_wdata : 64'd0;
    #1;
    check("idle_grant", grant_owner, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_stall", stall, 1);
    m_last   = owner;
    aborted  = (delay >= TIMEOUT_P);
    busy_len = aborted ? TIMEOUT_P : delay + 1;
    got_rd   = '0;
    for (int i = 1; i <= busy_len; i++) begin
      @(negedge clk);
      check("busy_mem_req", mem_req, 1);
      check("busy_mem_addr", mem_addr, exp_addr);
      check("busy_mem_we", mem_we, exp_we);
      check("busy_mem_wdata", mem_wdata, exp_wdata);
      check("busy_grant", grant_owner, owner);
      check("busy_stall", stall, 1);
      check("busy_acks", {if_ack, d_ack}, 0);
      mem_ready = (i == delay + 1);
      mem_rdata = mem_ready ? rdat : rnd64();
      if (mem_ready) got_rd = rdat;
      if (perturb) begin
        if (owner == 1) if_addr = rnd64();
        else begin
          d_addr  = rnd64();
          d_wdata = rnd64();
        end
      end
    end
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = rnd64();
    if (aborted) m_bus_err = 1'b1;
    if (owner == 1) m_if_rdata = aborted ? 32'd0 : got_rd[31:0];
    else if (!exp_we) m_d_rdata = aborted ? 64'd0 : got_rd;
    other_pending = (owner == 1) ? d_req : if_req;
    check("done_if_ack", if_ack, (owner == 1));
    check("done_d_ack", d_ack, (owner == 2));
    check("done_mem_req", mem_req, 0);
    check("done_grant", grant_owner, owner);
    check("done_if_rdata", if_rdata, m_if_rdata);
    check("done_d_rdata", d_rdata, m_d_rdata);
    check("done_bus_error", bus_error, m_bus_err);
    check("done_stall", stall, other_pending);
    if (owner == 1) if_req = 1'b0;
    else d_req = 1'b0;
    @(negedge clk);
    check("post_acks", {if_ack, d_ack}, 0);
    check("post_grant", grant_owner, 0);
    check("post_mem_req", mem_req, 0);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = rnd64();
  endtask

  // Drives one round of requests at an IDLE negedge and serves them in the
  // order the round-robin rule dictates.
  task automatic run_round(input bit ri, input bit rdq, input logic [63:0] ia,
                           input logic [63:0] da, input bit we, input logic [63:0] wd,
                           input int d1, input logic [63:0] rd1,
                           input int d2, input logic [63:0] rd2, input bit perturb);
    int first;
    if_req  = ri;
    if_addr = ia;
    d_req   = rdq;
    d_addr  = da;
    d_we    = we;
    d_wdata = wd;
    if (!ri && !rdq) begin
      #1;
      check("quiet_stall", stall, 0);
      @(negedge clk);
      check("quiet_mem_req", mem_req, 0);
      check("quiet_grant", grant_owner, 0);
      return;
    end
    if (ri && rdq) first = (m_last == 1) ? 2 : 1;
    else first = ri ? 1 : 2;
    serve(first, d1, rd1, perturb);
    if (ri && rdq) serve(3 - first, d2, rd2, perturb);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Fetch only: one-cycle memory, three cycles request to IDLE.
    run_round(1, 0, 64'h40, 0, 0, 0, 0, 64'h00500093, 0, 0, 0);
    check("fetch_word", if_rdata, 32'h00500093);

    // First tie after reset goes to data, then fetch.
    do_reset();
    run_round(1, 1, 64'h44, 64'h100, 0, 0, 1, 64'h1111_2222_3333_4444,
              0, 64'h0000_0000_0011_0113, 0);
    check("tie_d_rdata", d_rdata, 64'h1111_2222_3333_4444);
    check("tie_if_rdata", if_rdata, 32'h0011_0113);

    // Store, five BUSY cycles, ready on the cycle the count hits TIMEOUT.
    run_round(0, 1, 0, 64'h200, 1, 64'hDEAD_BEEF_CAFE_F00D, 4, rnd64(), 0, 0, 0);
    check("store_keeps_d_rdata", d_rdata, 64'h1111_2222_3333_4444);
    check("ready_at_limit_no_err", bus_error, 0);

    // Last owner is data now, so this tie goes to fetch first.
    run_round(1, 1, 64'h48, 64'h108, 0, 0, 0, 64'hAAAA_BBBB, 2, 64'h5555, 0);

    // Timeout abort on a load, then the flag survives a good access.
    run_round(0, 1, 0, 64'h500, 0, 0, 100, 0, 0, 0, 0);
    check("timeout_d_rdata", d_rdata, 0);
    check("timeout_bus_error", bus_error, 1);
    run_round(1, 0, 64'h60, 0, 0, 0, 1, 64'h1234_5678, 0, 0, 0);
    check("sticky_bus_error", bus_error, 1);

    // Reset while in BUSY_D: port drops, no ack, fetch then works.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h300;
    @(negedge clk);
    check("rbusy_mem_req", mem_req, 1);
    check("rbusy_grant", grant_owner, 2);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rbusy_drop_req", mem_req, 0);
    check("rbusy_no_ack", d_ack, 0);
    check("rbusy_idle", grant_owner, 0);
    check("rbusy_err_clr", bus_error, 0);
    @(negedge clk);
    check("rbusy_no_ack2", d_ack, 0);
    run_round(1, 0, 64'h80, 0, 0, 0, 2, 64'h0000_0000_0040_0513, 0, 0, 0);

    // Randomized rounds.
    for (int r = 0; r < 80; r++) begin
      run_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd64(), rnd64(),
                1'($urandom_range(0, 1)), rnd64(),
                int'($urandom_range(0, 7)), rnd64(),
                int'($urandom_range(0, 7)), rnd64(),
                1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
